// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 text controller.
// Optional hex decode is controlled by LCD_HEX_DECODE_EN (see lcd_text_ctrl).
package lcd_pkg;

   typedef enum logic [1:0] {StPwrup, StInit, StSetpos, StWrite} lcd_state_e;

   // 4 wake/mode nibbles followed by 4 command bytes sent as nibble pairs
   localparam int unsigned INIT_STEPS = 12;

   localparam logic [3:0] INIT_NIB_WAKE = 4'h3;
   localparam logic [3:0] INIT_NIB_4BIT = 4'h2;
   localparam logic [7:0] CMD_FUNC_SET  = 8'h28;
   localparam logic [7:0] CMD_ENTRY     = 8'h06;
   localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
   localparam logic [7:0] CMD_CLEAR     = 8'h01;

   function automatic logic [7:0] init_cmd(input logic [1:0] sel);
      logic [7:0] cmd;
      case (sel)
         2'd0:    cmd = CMD_FUNC_SET;
         2'd1:    cmd = CMD_ENTRY;
         2'd2:    cmd = CMD_DISP_ON;
         default: cmd = CMD_CLEAR;
      endcase
      return cmd;
   endfunction

   // DDRAM start address of each line; lines 2/3 continue lines 0/1
   function automatic logic [6:0] row_offset(input logic [1:0] row, input int unsigned cols);
      logic [6:0] c;
      logic [6:0] off;
      c = 7'(cols);
      case (row)
         2'd0:    off = 7'h00;
         2'd1:    off = 7'h40;
         2'd2:    off = c;
         default: off = 7'h40 + c;
      endcase
      return off;
   endfunction

   function automatic logic [7:0] hex_ascii(input logic [3:0] v);
      return (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h37 + {4'h0, v});
   endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// Sends one 4-bit nibble: holds data/rs for the whole wait, pulses E after
// one setup cycle, and flags done on the last cycle of the wait.
module lcd_nibble_tx #(
   parameter int unsigned E_CYC = 12
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_i,
   input  logic [3:0]  nib_i,
   input  logic        rs_i,
   input  logic [31:0] wait_i,
   output logic        lcd_e_o,
   output logic        lcd_rs_o,
   output logic [3:0]  lcd_d_o,
   output logic        done_o
);

   logic        busy_q, busy_d;
   logic        e_q, e_d;
   logic        rs_q, rs_d;
   logic [3:0]  d_q, d_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] wait_q, wait_d;

   always_comb begin
      done_o = busy_q && (cnt_q == wait_q - 32'd1);
      busy_d = busy_q;
      e_d    = e_q;
      rs_d   = rs_q;
      d_d    = d_q;
      cnt_d  = cnt_q;
      wait_d = wait_q;
      if (start_i) begin
         busy_d = 1'b1;
         e_d    = 1'b0;
         rs_d   = rs_i;
         d_d    = nib_i;
         cnt_d  = '0;
         wait_d = wait_i;
      end else if (done_o) begin
         busy_d = 1'b0;
         e_d    = 1'b0;
      end else if (busy_q) begin
         cnt_d = cnt_q + 32'd1;
         // E is high while the new count lies in 1..E_CYC
         e_d   = (cnt_q < E_CYC);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_q <= 1'b0;
         e_q    <= 1'b0;
         rs_q   <= 1'b0;
         d_q    <= '0;
         cnt_q  <= '0;
         wait_q <= '0;
      end else begin
         busy_q <= busy_d;
         e_q    <= e_d;
         rs_q   <= rs_d;
         d_q    <= d_d;
         cnt_q  <= cnt_d;
         wait_q <= wait_d;
      end
   end

   assign lcd_e_o  = e_q;
   assign lcd_rs_o = rs_q;
   assign lcd_d_o  = d_q;

endmodule

// File: rtl/lcd_text_ctrl.sv
// HD44780 4-bit text controller: power-up/init, then endless refresh of a
// ROWS x COLS character buffer. Define LCD_HEX_DECODE_EN to add the wr_hex_i input.
module lcd_text_ctrl
   import lcd_pkg::*;
#(
   parameter int unsigned ROWS    = 2,
   parameter int unsigned COLS    = 16,
   parameter int unsigned T_PWRUP = 750000,
   parameter int unsigned T_NIB   = 65,
   parameter int unsigned T_CMD   = 2048,
   parameter int unsigned T_CLR   = 84015,
   parameter int unsigned E_CYC   = 12
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_en_i,
   input  logic [1:0] wr_row_i,
   input  logic [4:0] wr_col_i,
   input  logic [7:0] wr_data_i,
`ifdef LCD_HEX_DECODE_EN
   input  logic       wr_hex_i,
`endif
   output logic       wr_ready_o,
   output logic       frame_done_o,
   output logic       lcd_e_o,
   output logic       lcd_rs_o,
   output logic       lcd_rw_o,
   output logic [3:0] lcd_d_o
);

   localparam int unsigned NCHAR = ROWS * COLS;
   localparam int unsigned BufAw = (NCHAR > 1) ? $clog2(NCHAR) : 1;

   lcd_state_e  state_q, state_d;
   logic [4:0]  idx_q, idx_d;
   logic        lo_q, lo_d;
   logic [1:0]  row_q, row_d;
   logic [7:0]  byte_q, byte_d;
   logic [31:0] pwr_cnt_q, pwr_cnt_d;
   logic        ready_q, ready_d;
   logic        frame_q, frame_d;
   logic [7:0]  buf_q [NCHAR];

   logic             advance;
   logic             tx_rs, tx_done;
   logic [3:0]       tx_nib;
   logic [31:0]      tx_wait;
   logic [7:0]       cur_byte, wr_byte;
   logic [1:0]       init_sel;
   logic [BufAw-1:0] rd_idx, wr_idx;
   logic             wr_ok;

   always_comb begin
      wr_byte = wr_data_i;
`ifdef LCD_HEX_DECODE_EN
      if (wr_hex_i) wr_byte = hex_ascii(wr_data_i[3:0]);
`endif
      wr_ok  = wr_en_i && ready_q && (32'(wr_row_i) < ROWS) && (32'(wr_col_i) < COLS);
      wr_idx = BufAw'(32'(wr_row_i) * COLS + 32'(wr_col_i));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NCHAR; i++) buf_q[i] <= 8'h20;
      end else if (wr_ok) begin
         buf_q[wr_idx] <= wr_byte;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      lo_d      = lo_q;
      row_d     = row_q;
      byte_d    = byte_q;
      pwr_cnt_d = pwr_cnt_q;
      ready_d   = ready_q;
      frame_d   = 1'b0;
      advance   = 1'b0;
      tx_nib    = 4'h0;
      tx_rs     = 1'b0;
      tx_wait   = T_CMD;
      cur_byte  = '0;
      init_sel  = '0;
      rd_idx    = '0;

      if (state_q == StPwrup) begin
         if (pwr_cnt_q == T_PWRUP - 1) advance = 1'b1;
         else pwr_cnt_d = pwr_cnt_q + 32'd1;
      end else begin
         advance = tx_done;
      end

      // Step to the next nibble position
      if (advance) begin
         unique case (state_q)
            StPwrup: begin
               state_d   = StInit;
               idx_d     = '0;
               pwr_cnt_d = '0;
            end
            StInit: begin
               if (idx_q == 5'(INIT_STEPS - 1)) begin
                  state_d = StSetpos;
                  row_d   = '0;
                  lo_d    = 1'b0;
                  ready_d = 1'b1;
               end else begin
                  idx_d = idx_q + 5'd1;
               end
            end
            StSetpos: begin
               if (!lo_q) begin
                  lo_d = 1'b1;
               end else begin
                  state_d = StWrite;
                  idx_d   = '0;
                  lo_d    = 1'b0;
               end
            end
            StWrite: begin
               if (!lo_q) begin
                  lo_d = 1'b1;
               end else if (32'(idx_q) == COLS - 1) begin
                  state_d = StSetpos;
                  lo_d    = 1'b0;
                  if (32'(row_q) == ROWS - 1) begin
                     row_d   = '0;
                     frame_d = 1'b1;
                  end else begin
                     row_d = row_q + 2'd1;
                  end
               end else begin
                  idx_d = idx_q + 5'd1;
                  lo_d  = 1'b0;
               end
            end
            default: ;
         endcase
      end

      // Nibble content for the position being entered
      case (state_d)
         StInit: begin
            if (idx_d < 5'd4) begin
               tx_nib  = (idx_d == 5'd3) ? INIT_NIB_4BIT : INIT_NIB_WAKE;
               tx_wait = T_CMD;
            end else begin
               init_sel = 2'(idx_d[3:1] - 3'd2);
               cur_byte = init_cmd(init_sel);
               tx_nib   = idx_d[0] ? cur_byte[3:0] : cur_byte[7:4];
               tx_wait  = !idx_d[0] ? T_NIB : ((cur_byte == CMD_CLEAR) ? T_CLR : T_CMD);
            end
         end
         StSetpos: begin
            cur_byte = {1'b1, row_offset(row_d, COLS)};
            tx_nib   = lo_d ? cur_byte[3:0] : cur_byte[7:4];
            tx_wait  = lo_d ? T_CMD : T_NIB;
         end
         StWrite: begin
            rd_idx = BufAw'(32'(row_d) * COLS + 32'(idx_d));
            // Character is captured as its high nibble starts
            cur_byte = lo_d ? byte_q : buf_q[rd_idx];
            if (advance && !lo_d) byte_d = cur_byte;
            tx_rs   = 1'b1;
            tx_nib  = lo_d ? cur_byte[3:0] : cur_byte[7:4];
            tx_wait = lo_d ? T_CMD : T_NIB;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StPwrup;
         idx_q     <= '0;
         lo_q      <= 1'b0;
         row_q     <= '0;
         byte_q    <= '0;
         pwr_cnt_q <= '0;
         ready_q   <= 1'b0;
         frame_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         lo_q      <= lo_d;
         row_q     <= row_d;
         byte_q    <= byte_d;
         pwr_cnt_q <= pwr_cnt_d;
         ready_q   <= ready_d;
         frame_q   <= frame_d;
      end
   end

   lcd_nibble_tx #(
      .E_CYC (E_CYC)
   ) u_tx (
      .clk      (clk),
      .reset    (reset),
      .start_i  (advance),
      .nib_i    (tx_nib),
      .rs_i     (tx_rs),
      .wait_i   (tx_wait),
      .lcd_e_o  (lcd_e_o),
      .lcd_rs_o (lcd_rs_o),
      .lcd_d_o  (lcd_d_o),
      .done_o   (tx_done)
   );

   assign wr_ready_o   = ready_q;
   assign frame_done_o = frame_q;
   assign lcd_rw_o     = 1'b0;

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// Bench for lcd_text_ctrl: decodes the LCD bus into bytes and checks init,
// frame contents, write semantics and reset against a character-array model.
module tb_lcd_text_ctrl;

   localparam int unsigned ROWS      = 2;
   localparam int unsigned COLS      = 16;
   localparam int unsigned T_PWRUP   = 100;
   localparam int unsigned T_NIB     = 20;
   localparam int unsigned T_CMD     = 30;
   localparam int unsigned T_CLR     = 60;
   localparam int unsigned E_CYC     = 4;
   localparam int unsigned NCHAR     = ROWS * COLS;
   localparam int unsigned FRAME_LEN = ROWS * (COLS + 1);

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       wr_en = 1'b0;
   logic [1:0] wr_row = '0;
   logic [4:0] wr_col = '0;
   logic [7:0] wr_data = '0;
   logic       wr_hex = 1'b0;
   logic       wr_ready, frame_done, lcd_e, lcd_rs, lcd_rw;
   logic [3:0] lcd_d;

   always #5 clk = ~clk;

   lcd_text_ctrl #(
      .ROWS    (ROWS),
      .COLS    (COLS),
      .T_PWRUP (T_PWRUP),
      .T_NIB   (T_NIB),
      .T_CMD   (T_CMD),
      .T_CLR   (T_CLR),
      .E_CYC   (E_CYC)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .wr_en_i      (wr_en),
      .wr_row_i     (wr_row),
      .wr_col_i     (wr_col),
      .wr_data_i    (wr_data),
`ifdef LCD_HEX_DECODE_EN
      .wr_hex_i     (wr_hex),
`endif
      .wr_ready_o   (wr_ready),
      .frame_done_o (frame_done),
      .lcd_e_o      (lcd_e),
      .lcd_rs_o     (lcd_rs),
      .lcd_rw_o     (lcd_rw),
      .lcd_d_o      (lcd_d)
   );

   typedef struct packed {
      logic       rs;
      logic [7:0] b;
   } lcd_byte_t;

   typedef struct {
      int         row;
      int         col;
      logic [7:0] data;
      logic       hex;
      int         exp_pos;
      logic [7:0] exp_char;
   } wvec_t;

   lcd_byte_t  stream[$];
   lcd_byte_t  frame[$];
   lcd_byte_t  init_tbl[8];
   wvec_t      wtbl[6];
   logic [7:0] model[NCHAR];
   logic [7:0] expbuf[NCHAR];
   int         frame_cnt = 0;
   int         vectors = 0;
   int         miscompares = 0;
   bit         hex_on;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] to_ascii(input logic [3:0] v);
      return (v < 10) ? 8'(8'h30 + v) : 8'(8'h41 + (v - 10));
   endfunction

   // Bus decoder: every E rise latches a nibble; first four after reset are single
   initial begin : monitor
      logic       e_prev;
      int         e_len;
      int         nib_cnt;
      logic [3:0] hi;
      e_prev = 1'b0;
      e_len = 0;
      nib_cnt = 0;
      hi = '0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            e_prev = 1'b0;
            e_len = 0;
            nib_cnt = 0;
            stream.delete();
         end else begin
            if (lcd_e && !e_prev) begin
               if (nib_cnt < 4) stream.push_back({lcd_rs, 4'h0, lcd_d});
               else if ((nib_cnt % 2) == 0) hi = lcd_d;
               else stream.push_back({lcd_rs, hi, lcd_d});
               nib_cnt++;
            end
            if (lcd_e) begin
               e_len++;
            end else if (e_prev) begin
               check("e_width", e_len, E_CYC);
               e_len = 0;
            end
            e_prev = lcd_e;
            if (frame_done) begin
               frame = stream;
               stream.delete();
               frame_cnt++;
            end
         end
      end
   end

   task automatic write(input int row, input int col, input logic [7:0] data, input logic hex);
      @(negedge clk);
      check("wr_ready_at_write", wr_ready, 1);
      wr_en   = 1'b1;
      wr_row  = 2'(row);
      wr_col  = 5'(col);
      wr_data = data;
      wr_hex  = hex;
      @(negedge clk);
      wr_en = 1'b0;
      if (row < int'(ROWS) && col < int'(COLS))
         model[row * COLS + col] = (hex_on && hex) ? to_ascii(data[3:0]) : data;
   endtask

   task automatic wait_frames(input int n);
      int target;
      int budget;
      target = frame_cnt + n;
      budget = n * 5000;
      while (frame_cnt < target && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      check("frame_timeout", int'(frame_cnt >= target), 1);
   endtask

   task automatic check_pwrup();
      int first;
      first = -1;
      for (int c = 1; c <= int'(T_PWRUP) + 50; c++) begin
         @(posedge clk);
         #1;
         if (lcd_e) begin
            first = c;
            check("pwrup_d", lcd_d, 3);
            check("pwrup_rs", lcd_rs, 0);
            break;
         end
      end
      check("pwrup_e_cycle", first, T_PWRUP + 1);
   endtask

   task automatic check_init();
      int budget;
      budget = 4000;
      while (!wr_ready && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      check("init_ready", wr_ready, 1);
      check("init_len", stream.size(), 8);
      for (int i = 0; i < 8; i++)
         check($sformatf("init_byte%0d", i), (i < stream.size()) ? int'(stream[i]) : -1,
               init_tbl[i]);
   endtask

   task automatic check_frame();
      int p;
      int off;
      check("frame_len", frame.size(), FRAME_LEN);
      for (int r = 0; r < int'(ROWS); r++) begin
         off = (r % 2) * 64 + (r / 2) * int'(COLS);
         p = r * (int'(COLS) + 1);
         check($sformatf("r%0d_setpos", r), (p < frame.size()) ? int'(frame[p]) : -1,
               {1'b0, 8'(8'h80 + off)});
         for (int c = 0; c < int'(COLS); c++) begin
            p = r * (int'(COLS) + 1) + 1 + c;
            check($sformatf("r%0d_c%0d", r, c), (p < frame.size()) ? int'(frame[p]) : -1,
                  {1'b1, expbuf[r * COLS + c]});
         end
      end
   endtask

   initial begin
      int budget;
      int n;
`ifdef LCD_HEX_DECODE_EN
      hex_on = 1'b1;
`else
      hex_on = 1'b0;
`endif
      init_tbl = '{{1'b0, 8'h03}, {1'b0, 8'h03}, {1'b0, 8'h03}, {1'b0, 8'h02},
                   {1'b0, 8'h28}, {1'b0, 8'h06}, {1'b0, 8'h0C}, {1'b0, 8'h01}};
      wtbl[0] = '{1, 0, 8'h48, 1'b0, 18, 8'h48};
      wtbl[1] = '{0, 15, 8'h41, 1'b0, 16, 8'h41};
      wtbl[2] = '{3, 0, 8'h55, 1'b0, -1, 8'h00};
      wtbl[3] = '{0, 20, 8'h66, 1'b0, -1, 8'h00};
      wtbl[4] = '{2, 5, 8'h77, 1'b0, -1, 8'h00};
      wtbl[5] = '{1, 15, 8'h0B, 1'b1, 33, hex_on ? 8'h42 : 8'h0B};
      foreach (model[i]) model[i] = 8'h20;

      repeat (3) @(negedge clk);
      check("rst_e", lcd_e, 0);
      check("rst_rs", lcd_rs, 0);
      check("rst_d", lcd_d, 0);
      check("rst_rw", lcd_rw, 0);
      check("rst_ready", wr_ready, 0);
      check("rst_frame_done", frame_done, 0);

      reset = 1'b1;
      check_pwrup();
      check_init();
      wait_frames(2);
      expbuf = model;
      check_frame();

      foreach (wtbl[i]) write(wtbl[i].row, wtbl[i].col, wtbl[i].data, wtbl[i].hex);
      wait_frames(2);
      expbuf = model;
      check_frame();
      foreach (wtbl[i])
         if (wtbl[i].exp_pos >= 0)
            check($sformatf("tbl%0d", i),
                  (wtbl[i].exp_pos < frame.size()) ? int'(frame[wtbl[i].exp_pos]) : -1,
                  {1'b1, wtbl[i].exp_char});

      // Write ahead of the scan shows now; write behind it waits a frame
      wait_frames(1);
      write(1, 10, 8'h59, 1'b0);
      expbuf = model;
      budget = 2000;
      while (stream.size() < 3 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      check("scan_progress", int'(stream.size() >= 3), 1);
      write(0, 0, 8'h58, 1'b0);
      wait_frames(1);
      check_frame();
      expbuf = model;
      wait_frames(1);
      check_frame();

      for (int it = 0; it < 4; it++) begin
         n = int'($urandom_range(1, 6));
         for (int k = 0; k < n; k++)
            write(int'($urandom_range(0, 3)), int'($urandom_range(0, 31)),
                  8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
         wait_frames(2);
         expbuf = model;
         check_frame();
      end

      // Abort in the middle of a character nibble
      budget = 5000;
      while (!(lcd_e && lcd_rs) && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      check("found_write_nibble", int'(lcd_e && lcd_rs), 1);
      #2 reset = 1'b0;
      #1;
      check("abort_e", lcd_e, 0);
      check("abort_d", lcd_d, 0);
      check("abort_rs", lcd_rs, 0);
      check("abort_ready", wr_ready, 0);
      check("abort_frame_done", frame_done, 0);
      foreach (model[i]) model[i] = 8'h20;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      check_pwrup();
      check_init();
      wait_frames(2);
      expbuf = model;
      check_frame();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/lcd_text_ctrl.md
LCD_TEXT_CTRL -- requirements
Module: lcd_text_ctrl

Interface
REQ-001 Parameter ROWS, 2, number of display lines (1..4).
REQ-002 Parameter COLS, 16, characters per line (1..20).
REQ-003 Parameter T_PWRUP, 750000, power-up wait in clk cycles.
REQ-004 Parameter T_NIB, 65, wait after a high nibble.
REQ-005 Parameter T_CMD, 2048, wait after a low nibble or init nibble.
REQ-006 Parameter T_CLR, 84015, wait after the clear-display command.
REQ-007 Parameter E_CYC, 12, lcd_e high width in cycles.
REQ-008 clk  in  1  clock.
REQ-009 reset  in  1  asynchronous, active-low reset.
REQ-010 wr_en  in  1  character write strobe.
REQ-011 wr_row  in  2  target line.
REQ-012 wr_col  in  5  target column.
REQ-013 wr_data  in  8  character code.
REQ-014 wr_ready  out  1  high when init is complete and writes are accepted.
REQ-015 frame_done  out  1  one-cycle pulse after the last character of the last line is sent.
REQ-016 lcd_e, lcd_rs, lcd_rw  out  1 each  HD44780 strobes; lcd_rw is constant 0.
REQ-017 lcd_d  out  4  4-bit data bus.

Function
REQ-018 The block SHALL hold a ROWS*COLS byte character buffer, initialised to 0x20 at reset.
REQ-019 A write SHALL be accepted when wr_en=1 and wr_ready=1 in the same cycle, updating the buffer at the next clk edge.
REQ-020 A write with wr_row>=ROWS or wr_col>=COLS SHALL be ignored without error.
REQ-021 The state machine SHALL use the states PWRUP, INIT, SETPOS, WRITE and then loop SETPOS->WRITE over rows 0..ROWS-1 indefinitely.
REQ-022 PWRUP SHALL wait T_PWRUP cycles with lcd_e=0.
REQ-023 INIT SHALL send the nibbles 3,3,3,2 (T_CMD each) followed by the bytes 0x28, 0x06, 0x0C and 0x01 (last wait T_CLR), with rs=0.
REQ-024 SETPOS SHALL send byte 0x80|offset, rs=0, where offset = {0x00, 0x40, COLS, 0x40+COLS}[row].
REQ-025 WRITE SHALL send COLS bytes from the current row with rs=1; the buffer is sampled when each byte's high nibble starts.
REQ-026 Each byte SHALL be sent as the high nibble, then T_NIB wait, then the low nibble, then T_CMD wait (T_CLR for clear).
REQ-027 Per nibble, lcd_d and lcd_rs SHALL be stable for the entire wait, and lcd_e SHALL be 1 for exactly E_CYC cycles starting 1 cycle after the nibble begins.
REQ-028 wr_ready SHALL rise the cycle INIT completes and remain 1 until reset.
REQ-029 frame_done SHALL pulse when the last low-nibble wait of row ROWS-1 expires; the sequencer then returns to SETPOS row 0.
REQ-030 A write to a character already sent this frame SHALL appear on the next frame; a write to a character not yet sent SHALL appear in the current frame.

Reset
REQ-031 On reset assertion, the block SHALL drive lcd_e=0, lcd_rs=0, lcd_d=0, wr_ready=0 and frame_done=0, set the state to PWRUP and clear all counters, asynchronously.
REQ-032 Reset mid-operation SHALL abort any nibble in progress and restart the full power-up sequence.

Configuration
REQ-033 Macro LCD_HEX_DECODE_EN: when defined, an extra input wr_hex (1 bit) is present, and a write with wr_hex=1 stores the ASCII code of wr_data[3:0] ('0'-'9' as 0x30-0x39, 'A'-'F' as 0x41-0x46).
REQ-034 When LCD_HEX_DECODE_EN is undefined, the wr_hex port is absent and wr_data is always stored raw.

Structure
REQ-035 Package lcd_pkg SHALL hold the state enum, the init command constants, and the row-offset table.
REQ-036 Sub-module lcd_nibble_tx SHALL handle one nibble: drive lcd_d/lcd_rs, generate the E pulse, count the wait, and return done; the top sequences bytes.

Verification
REQ-037 Release reset with T_PWRUP=100 -> first lcd_e rise at cycle 101, with lcd_d=3 and rs=0.
REQ-038 Full init -> captured byte stream 3,3,3,2,0x28,0x06,0x0C,0x01, followed by wr_ready=1.
REQ-039 ROWS=2, COLS=16, write 'H'(0x48) to row1 col0 -> next frame shows SETPOS 0xC0, then first rs=1 byte 0x48.
REQ-040 Write row=3 with ROWS=2, or col=20 -> buffer unchanged and captured frames identical.
REQ-041 With LCD_HEX_DECODE_EN, wr_hex=1 and wr_data=0x0B -> displayed byte 0x42; with the macro undefined, wr_data=0x0B is sent raw.
REQ-042 Assert reset during a WRITE nibble -> lcd_e=0 the same cycle; after release, the full PWRUP/INIT sequence repeats.
